// File: rtl/ks_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
package ks_adder_pkg;

    localparam int MAX_WIDTH = 128;

    // Generate/propagate pair for one bit (or one prefix group)
    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Cycles from accepted beat to out_valid: operand register plus one per prefix group
    function automatic int ks_latency(input int w, input int pe);
        return 1 + (clog2(w) + pe - 1) / pe;
    endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational row of Kogge-Stone black/grey cells at a fixed span DIST.
module ks_prefix_level
    import ks_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  pg_t [WIDTH-1:0] pg,
    output pg_t [WIDTH-1:0] pg_nxt
);

    always_comb begin
        pg_nxt = pg;
        for (int i = DIST; i < WIDTH; i++) begin
            pg_nxt[i].g = pg[i].g | (pg[i].p & pg[i-DIST].g);
            pg_nxt[i].p = pg[i].p & pg[i-DIST].p;
        end
    end

endmodule

// File: rtl/ks_pipe_adder.sv
// Pipelined Kogge-Stone add/subtract with global-stall valid/ready flow control.
// Optional signed-overflow output enabled by defining KS_PIPE_ADDER_OVF_EN.
module ks_pipe_adder
    import ks_adder_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int PIPE_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef KS_PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int LOG2W = clog2(WIDTH);

    if (WIDTH < 4 || WIDTH > MAX_WIDTH || (1 << LOG2W) != WIDTH) begin : g_bad_width
        $error("ks_pipe_adder: WIDTH must be a power of two in 4..128");
    end
    if (PIPE_EVERY < 1 || PIPE_EVERY > LOG2W) begin : g_bad_pipe
        $error("ks_pipe_adder: PIPE_EVERY must be in 1..clog2(WIDTH)");
    end

    // Every stage moves together; a stalled output freezes the whole pipe
    logic adv;
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    assign b_eff = sub ? ~b : b;
    assign c_eff = cin ^ sub;

    // ---- stage 0: operand generate/propagate ----
    logic [WIDTH-1:0] g_p0, p_p0;
    logic             c_p0, vld_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      vld_p0 <= 1'b0;
        else if (adv) vld_p0 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            g_p0 <= a & b_eff;
            p_p0 <= a ^ b_eff;
            c_p0 <= c_eff;
        end
    end

    // Carry-in is folded into bit 0 so G[i] becomes the true carry out of bit i
    pg_t [WIDTH-1:0] pg_p0;
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pg_p0[i].g = g_p0[i];
            pg_p0[i].p = p_p0[i];
        end
        pg_p0[0].g = g_p0[0] | (p_p0[0] & c_p0);
    end

    for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
        localparam bit REG_AFTER = ((k + 1) % PIPE_EVERY == 0) && (k != LOG2W - 1);

        pg_t [WIDTH-1:0]  pg_d, pg_row, pg_q;
        logic [WIDTH-1:0] prop_d, prop_q;
        logic             c_d, c_q, vld_d, vld_q;

        if (k == 0) begin : g_src
            assign pg_d   = pg_p0;
            assign prop_d = p_p0;
            assign c_d    = c_p0;
            assign vld_d  = vld_p0;
        end else begin : g_src
            assign pg_d   = g_lvl[k-1].pg_q;
            assign prop_d = g_lvl[k-1].prop_q;
            assign c_d    = g_lvl[k-1].c_q;
            assign vld_d  = g_lvl[k-1].vld_q;
        end

        ks_prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_row (
            .pg     (pg_d),
            .pg_nxt (pg_row)
        );

        // ---- stage boundary after this prefix row ----
        if (REG_AFTER) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst)      vld_q <= 1'b0;
                else if (adv) vld_q <= vld_d;
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    pg_q   <= pg_row;
                    prop_q <= prop_d;
                    c_q    <= c_d;
                end
            end
        end else begin : g_wire
            assign pg_q   = pg_row;
            assign prop_q = prop_d;
            assign c_q    = c_d;
            assign vld_q  = vld_d;
        end
    end

    logic [WIDTH-1:0] carry, prop_f, unused_grp_p;
    logic             c_f, vld_f;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            carry[i]        = g_lvl[LOG2W-1].pg_q[i].g;
            unused_grp_p[i] = g_lvl[LOG2W-1].pg_q[i].p;
        end
    end

    assign prop_f = g_lvl[LOG2W-1].prop_q;
    assign c_f    = g_lvl[LOG2W-1].c_q;
    assign vld_f  = g_lvl[LOG2W-1].vld_q;

    // ---- final stage: sum / carry-out register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef KS_PIPE_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (adv) begin
            out_valid <= vld_f;
            if (vld_f) begin
                sum  <= prop_f ^ {carry[WIDTH-2:0], c_f};
                cout <= carry[WIDTH-1];
`ifdef KS_PIPE_ADDER_OVF_EN
                ovf  <= carry[WIDTH-1] ^ carry[WIDTH-2];
`endif
            end
        end
    end

endmodule

// File: tb/tb_ks_pipe_adder.sv
// Directed self-checking bench for ks_pipe_adder (default 32-bit plus two small configs).
module tb_ks_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, out_ready, cin, sub, cout;
    logic [31:0] a, b, sum;
`ifdef KS_PIPE_ADDER_OVF_EN
    logic        ovf, unused_ovf16, unused_ovf8;
`endif

    logic        in_valid_s, cin_s, sub_s, out_ready_s;
    logic [15:0] a16, b16, sum16;
    logic        in_ready16, out_valid16, cout16;
    logic [7:0]  sum8;
    logic        in_ready8, out_valid8, cout8;

    int passed = 0;
    int total  = 0;

    ks_pipe_adder #(.WIDTH(32), .PIPE_EVERY(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef KS_PIPE_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    ks_pipe_adder #(.WIDTH(16), .PIPE_EVERY(1)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin_s), .sub(sub_s),
        .out_valid(out_valid16), .out_ready(out_ready_s), .sum(sum16), .cout(cout16)
`ifdef KS_PIPE_ADDER_OVF_EN
        , .ovf(unused_ovf16)
`endif
    );

    ks_pipe_adder #(.WIDTH(8), .PIPE_EVERY(3)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready8),
        .a(a16[7:0]), .b(b16[7:0]), .cin(cin_s), .sub(sub_s),
        .out_valid(out_valid8), .out_ready(out_ready_s), .sum(sum8), .cout(cout8)
`ifdef KS_PIPE_ADDER_OVF_EN
        , .ovf(unused_ovf8)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one beat with out_ready high and returns the first result seen
    task automatic issue_wait(input logic [31:0] ta, input logic [31:0] tb_v,
                              input logic tc, input logic ts,
                              output logic [31:0] rs, output logic rc,
                              output logic ro, output int lat);
        a = ta; b = tb_v; cin = tc; sub = ts;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        rs = sum; rc = cout; ro = 1'b0;
`ifdef KS_PIPE_ADDER_OVF_EN
        ro = ovf;
`endif
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (sum !== 32'h0) $display("FAIL reset_sum: got %h want 00000000", sum); else passed++;
        total++; if (cout !== 1'b0) $display("FAIL reset_cout: got %b want 0", cout); else passed++;
`ifdef KS_PIPE_ADDER_OVF_EN
        total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else passed++;
`endif
        rst = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_add();
        logic [31:0] rs; logic rc, ro; int lat;
        issue_wait(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, rs, rc, ro, lat);
        total++; if (lat != 4) $display("FAIL add_latency: got %0d want 4", lat); else passed++;
        total++; if (rs !== 32'h0000_0000) $display("FAIL add_wrap_sum: got %h want 00000000", rs); else passed++;
        total++; if (rc !== 1'b1) $display("FAIL add_wrap_cout: got %b want 1", rc); else passed++;
        issue_wait(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, rs, rc, ro, lat);
        total++; if (rs !== 32'h2345_678A) $display("FAIL add_cin_sum: got %h want 2345678a", rs); else passed++;
        total++; if (rc !== 1'b0) $display("FAIL add_cin_cout: got %b want 0", rc); else passed++;
    endtask

    task automatic test_sub();
        logic [31:0] rs; logic rc, ro; int lat;
        issue_wait(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, rs, rc, ro, lat);
        total++; if (rs !== 32'hFFFF_FFFE) $display("FAIL sub_neg_sum: got %h want fffffffe", rs); else passed++;
        total++; if (rc !== 1'b0) $display("FAIL sub_neg_cout: got %b want 0", rc); else passed++;
`ifdef KS_PIPE_ADDER_OVF_EN
        total++; if (ro !== 1'b0) $display("FAIL sub_neg_ovf: got %b want 0", ro); else passed++;
`endif
        issue_wait(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, rs, rc, ro, lat);
        total++; if (rs !== 32'h0000_0006) $display("FAIL sub_borrow_sum: got %h want 00000006", rs); else passed++;
        total++; if (rc !== 1'b1) $display("FAIL sub_borrow_cout: got %b want 1", rc); else passed++;
        issue_wait(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, rs, rc, ro, lat);
        total++; if (rs !== 32'hFFFF_FFFF) $display("FAIL sub_zero_sum: got %h want ffffffff", rs); else passed++;
        total++; if (rc !== 1'b0) $display("FAIL sub_zero_cout: got %b want 0", rc); else passed++;
    endtask

`ifdef KS_PIPE_ADDER_OVF_EN
    task automatic test_ovf();
        logic [31:0] rs; logic rc, ro; int lat;
        issue_wait(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, rs, rc, ro, lat);
        total++; if (rs !== 32'h8000_0000) $display("FAIL ovf_add_sum: got %h want 80000000", rs); else passed++;
        total++; if (ro !== 1'b1) $display("FAIL ovf_add_flag: got %b want 1", ro); else passed++;
        issue_wait(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, rs, rc, ro, lat);
        total++; if (rs !== 32'h7FFF_FFFF) $display("FAIL ovf_sub_sum: got %h want 7fffffff", rs); else passed++;
        total++; if (ro !== 1'b1) $display("FAIL ovf_sub_flag: got %b want 1", ro); else passed++;
        issue_wait(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, rs, rc, ro, lat);
        total++; if (ro !== 1'b0) $display("FAIL ovf_none_flag: got %b want 0", ro); else passed++;
    endtask
`endif

    task automatic test_back_to_back();
        int issued = 0, received = 0, stall = 0, cyc = 0, extra = 0;
        logic acc, pop;
        logic [31:0] popped, held, expv;
        out_ready = 1'b1;
        while (received < 10 && cyc < 200) begin
            in_valid = (issued < 10);
            a = 32'h1000_0000 + issued;
            b = issued * 32'h0101_0101;
            cin = 1'b0; sub = 1'b0;
            if (received >= 2 && stall < 12) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (stall == 1 && out_ready == 1'b0) held = sum;
            if (stall == 8 && out_ready == 1'b0) begin
                total++; if (in_ready !== 1'b0) $display("FAIL b2b_in_ready_full: got %b want 0", in_ready); else passed++;
                total++; if (out_valid !== 1'b1) $display("FAIL b2b_stall_valid: got %b want 1", out_valid); else passed++;
                total++; if (sum !== held) $display("FAIL b2b_held_sum: got %h want %h", sum, held); else passed++;
            end
            acc = in_valid & in_ready;
            pop = out_valid & out_ready;
            popped = sum;
            tick();
            cyc++;
            if (acc) issued++;
            if (pop) begin
                expv = 32'h1000_0000 + received + received * 32'h0101_0101;
                total++; if (popped !== expv) $display("FAIL b2b_result_%0d: got %h want %h", received, popped, expv); else passed++;
                received++;
            end
        end
        total++; if (received != 10) $display("FAIL b2b_count: got %0d want 10", received); else passed++;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid === 1'b1) extra++;
            tick();
        end
        total++; if (extra != 0) $display("FAIL b2b_no_duplicate: got %0d extra results want 0", extra); else passed++;
    endtask

    task automatic test_reset_midstream();
        int waitc = 0, seen = 0;
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            a = j + 1; b = j + 1; cin = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && waitc < 10) begin
            tick();
            waitc++;
        end
        total++; if (out_valid !== 1'b1) $display("FAIL rstmid_first_valid: got %b want 1", out_valid); else passed++;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (sum !== 32'h0) $display("FAIL rstmid_sum: got %h want 00000000", sum); else passed++;
        total++; if (cout !== 1'b0) $display("FAIL rstmid_cout: got %b want 0", cout); else passed++;
        tick(); tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        total++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", in_ready); else passed++;
        for (int i = 0; i < 8; i++) begin
            if (out_valid === 1'b1) seen++;
            tick();
        end
        total++; if (seen != 0) $display("FAIL rstmid_stale: got %0d results want 0", seen); else passed++;
    endtask

    task automatic test_widths();
        int lat, l8, l16;
        logic [7:0]  r8, e8;
        logic [15:0] r16, e16;
        logic        c8, c16, ec;
        out_ready_s = 1'b1;
        for (int v = 0; v < 2; v++) begin
            a16   = (v == 0) ? 16'hFFFF : 16'h0005;
            b16   = (v == 0) ? 16'h0001 : 16'h0007;
            sub_s = (v == 1);
            cin_s = 1'b0;
            e16   = (v == 0) ? 16'h0000 : 16'hFFFE;
            e8    = (v == 0) ? 8'h00 : 8'hFE;
            ec    = (v == 0);
            in_valid_s = 1'b1;
            tick();
            in_valid_s = 1'b0;
            lat = 1; l8 = 0; l16 = 0;
            r8 = '0; r16 = '0; c8 = 1'b0; c16 = 1'b0;
            while ((l8 == 0 || l16 == 0) && lat < 20) begin
                if (out_valid8 === 1'b1 && l8 == 0) begin l8 = lat; r8 = sum8; c8 = cout8; end
                if (out_valid16 === 1'b1 && l16 == 0) begin l16 = lat; r16 = sum16; c16 = cout16; end
                tick();
                lat++;
            end
            total++; if (l8 != 2) $display("FAIL w8_latency_%0d: got %0d want 2", v, l8); else passed++;
            total++; if (r8 !== e8) $display("FAIL w8_sum_%0d: got %h want %h", v, r8, e8); else passed++;
            total++; if (c8 !== ec) $display("FAIL w8_cout_%0d: got %b want %b", v, c8, ec); else passed++;
            total++; if (l16 != 5) $display("FAIL w16_latency_%0d: got %0d want 5", v, l16); else passed++;
            total++; if (r16 !== e16) $display("FAIL w16_sum_%0d: got %h want %h", v, r16, e16); else passed++;
            total++; if (c16 !== ec) $display("FAIL w16_cout_%0d: got %b want %b", v, c16, ec); else passed++;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid_s = 1'b0; out_ready_s = 1'b1; a16 = '0; b16 = '0; cin_s = 1'b0; sub_s = 1'b0;
        test_reset();
        test_add();
        test_sub();
`ifdef KS_PIPE_ADDER_OVF_EN
        test_ovf();
`endif
        test_back_to_back();
        test_reset_midstream();
        test_widths();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", passed, total);
        $fatal(1, "watchdog");
    end

endmodule
